// File: rtl/msu_data_buffer.sv
// MSU-1 data buffer: simple dual-port byte RAM, write-only port A from the MCU,
// read-only port B with a registered output serving the SNES data register.
module msu_data_buffer #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clkin,
  input  logic                  reset,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Power-up contents are zero; reset deliberately never touches the array.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clkin) begin
    if (wea && !reset) begin
      mem[addra] <= dina;
    end
  end

  // Read-first on collision: the read samples the array before this edge's write lands.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      doutb <= '0;
    end else begin
      doutb <= mem[addrb];
    end
  end

endmodule

// File: tb/tb_msu_data_buffer.sv
// Self-checking bench for msu_data_buffer against a behavioural byte-array model.
module tb_msu_data_buffer;

  logic        clkin = 1'b0;
  logic        reset = 1'b1;
  logic        wea   = 1'b0;
  logic [13:0] addra = '0;
  logic [7:0]  dina  = '0;
  logic [13:0] addrb = '0;
  logic [7:0]  doutb;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [16384];
  logic [7:0] exp_dout = 8'h00;

  msu_data_buffer #(.ADDR_WIDTH(14), .DATA_WIDTH(8)) dut (
    .clkin (clkin),
    .reset (reset),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .addrb (addrb),
    .doutb (doutb)
  );

  always #5 clkin = ~clkin;

  // Advance one rising edge; the model predicts what the read port returns for
  // the inputs held across that edge, then applies any write.
  task automatic step();
    logic [7:0] nxt;
    nxt = reset ? 8'h00 : model[addrb];
    if (wea && !reset) model[addra] = dina;
    @(posedge clkin);
    #1;
    exp_dout = nxt;
  endtask

  task automatic drive(input logic w, input logic [13:0] aa, input logic [7:0] da,
                       input logic [13:0] ab);
    wea = w; addra = aa; dina = da; addrb = ab;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 14'h0, 8'h0, 14'h0);
    step(); step();
    checks++;
    if (doutb !== 8'h00) begin
      errors++; $display("FAIL reset_initial: doutb=%02h expected=00", doutb);
    end
    reset = 1'b0;
    drive(1'b1, 14'h0010, 8'h5A, 14'h0010);
    step();
    drive(1'b0, 14'h0, 8'h0, 14'h0010);
    step();
    checks++;
    if (doutb !== 8'h5A) begin
      errors++; $display("FAIL reset_pre_data: doutb=%02h expected=5a", doutb);
    end
    // Asynchronous clear: no clock edge between assertion and check.
    reset = 1'b1;
    #1;
    checks++;
    if (doutb !== 8'h00) begin
      errors++; $display("FAIL reset_async: doutb=%02h expected=00", doutb);
    end
    drive(1'b1, 14'h0020, 8'h77, 14'h0010);
    step(); step();
    checks++;
    if (doutb !== 8'h00) begin
      errors++; $display("FAIL reset_hold: doutb=%02h expected=00", doutb);
    end
    reset = 1'b0;
    drive(1'b0, 14'h0, 8'h0, 14'h0000);
    step();
    checks++;
    if (doutb !== 8'h00) begin
      errors++; $display("FAIL reset_read0: doutb=%02h expected=00", doutb);
    end
    addrb = 14'h0010;
    step();
    checks++;
    if (doutb !== 8'h5A) begin
      errors++; $display("FAIL reset_mem_kept: doutb=%02h expected=5a", doutb);
    end
    addrb = 14'h0020;
    step();
    checks++;
    if (doutb !== 8'h00) begin
      errors++; $display("FAIL reset_write_inhibit: doutb=%02h expected=00", doutb);
    end
  endtask

  task automatic test_write_read();
    logic [13:0] adr [3];
    logic [7:0]  dat [3];
    logic [7:0]  prev;
    adr[0] = 14'h0000; dat[0] = 8'hA5;
    adr[1] = 14'h1234; dat[1] = 8'h3C;
    adr[2] = 14'h3FFF; dat[2] = 8'hFF;
    addrb = 14'h0020;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, adr[i], dat[i], 14'h0020);
      step();
    end
    wea = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      prev = doutb;
      addrb = adr[i];
      #1;
      checks++;
      if (doutb !== prev) begin
        errors++; $display("FAIL wr_latency_%0d: doutb=%02h expected=%02h", i, doutb, prev);
      end
      step();
      checks++;
      if (doutb !== dat[i]) begin
        errors++; $display("FAIL wr_read_%0d: doutb=%02h expected=%02h", i, doutb, dat[i]);
      end
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 14'h2000 + 14'(i), 8'(i), 14'h0);
      step();
    end
    wea = 1'b0;
    addrb = 14'h2000;
    for (int i = 1; i <= 256; i++) begin
      step();
      checks++;
      if (doutb !== 8'(i - 1) || doutb !== exp_dout) begin
        errors++; $display("FAIL stream_%0d: doutb=%02h expected=%02h", i, doutb, 8'(i - 1));
      end
      addrb = addrb + 14'd1;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 14'h3FFE + 14'(i), 8'($urandom_range(1, 255)), 14'h0);
      step();
    end
    wea = 1'b0;
    addrb = 14'h3FFD;
    step();
    for (int i = 0; i < 6; i++) begin
      addrb = addrb + 14'd1;
      step();
      checks++;
      if (doutb !== exp_dout || doutb !== model[addrb]) begin
        errors++; $display("FAIL wrap_%0d: addr=%04h doutb=%02h expected=%02h",
                           i, addrb, doutb, model[addrb]);
      end
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 14'h0100, 8'h11, 14'h0);
    step();
    drive(1'b1, 14'h0100, 8'h22, 14'h0100);
    step();
    checks++;
    if (doutb !== 8'h11) begin
      errors++; $display("FAIL collide_old: doutb=%02h expected=11", doutb);
    end
    wea = 1'b0;
    step();
    checks++;
    if (doutb !== 8'h22) begin
      errors++; $display("FAIL collide_new: doutb=%02h expected=22", doutb);
    end
  endtask

  task automatic test_write_inhibit();
    drive(1'b1, 14'h0200, 8'h44, 14'h0);
    step();
    drive(1'b0, 14'h0200, 8'h99, 14'h0);
    step(); step();
    addrb = 14'h0200;
    step();
    checks++;
    if (doutb !== 8'h44) begin
      errors++; $display("FAIL inhibit: doutb=%02h expected=44", doutb);
    end
  endtask

  task automatic test_independent();
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 14'h1000 + 14'(i), 8'($urandom), 14'h0000 + 14'(i));
      step();
      checks++;
      if (doutb !== exp_dout) begin
        errors++; $display("FAIL indep_read_%0d: doutb=%02h expected=%02h", i, doutb, exp_dout);
      end
    end
    wea = 1'b0;
    for (int i = 0; i < 64; i++) begin
      addrb = 14'h1000 + 14'(i);
      step();
      checks++;
      if (doutb !== model[addrb]) begin
        errors++; $display("FAIL indep_write_%0d: doutb=%02h expected=%02h", i, doutb, model[addrb]);
      end
    end
  endtask

  // Dense random traffic on a tiny address window to provoke collisions and resets.
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 19) == 0);
      drive(1'($urandom), 14'h0300 + 14'($urandom_range(0, 7)), 8'($urandom),
            14'h0300 + 14'($urandom_range(0, 7)));
      step();
      checks++;
      if (doutb !== exp_dout) begin
        errors++; $display("FAIL random_%0d: doutb=%02h expected=%02h", i, doutb, exp_dout);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) model[i] = 8'h00;
    test_reset();
    test_write_read();
    test_streaming();
    test_collision();
    test_write_inhibit();
    test_independent();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
